// File: rtl/breakout_pkg.sv
// Shared breakout types: FSM states, bounce-axis constants, index-width helper.
package breakout_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic SIDE_Y = 1'b0;
  localparam logic SIDE_X = 1'b1;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BRICK_IDX_W = idx_bits(4 * 8);

endpackage

// File: rtl/brick_hit_test.sv
// One brick box against the ball box: strict overlap test plus bounce axis
// (shallower penetration axis is the one that flips).
module brick_hit_test
  import breakout_pkg::*;
(
  input  logic        alive_i,
  input  logic [11:0] x1_i,
  input  logic [11:0] x2_i,
  input  logic [11:0] y1_i,
  input  logic [11:0] y2_i,
  input  logic [11:0] bx1_i,
  input  logic [11:0] bx2_i,
  input  logic [11:0] by1_i,
  input  logic [11:0] by2_i,
  output logic        hit_o,
  output logic        side_o
);

  logic [11:0] lo_x, hi_x, lo_y, hi_y, ox, oy;

  always_comb begin
    hit_o  = alive_i && (bx1_i < x2_i) && (bx2_i > x1_i) &&
             (by1_i < y2_i) && (by2_i > y1_i);
    lo_x   = (bx1_i > x1_i) ? bx1_i : x1_i;
    hi_x   = (bx2_i < x2_i) ? bx2_i : x2_i;
    lo_y   = (by1_i > y1_i) ? by1_i : y1_i;
    hi_y   = (by2_i < y2_i) ? by2_i : y2_i;
    // Only meaningful when hit_o is set, so both differences are positive.
    ox     = hi_x - lo_x;
    oy     = hi_y - lo_y;
    side_o = (ox >= oy) ? SIDE_Y : SIDE_X;
  end

endmodule

// File: rtl/brick_field.sv
// ROWS x COLS breakout brick wall: draw flag, one-brick-per-frame collision scan,
// score and clear state. Define ROW_POINTS_EN to score ROWS-r points per brick.
module brick_field
  import breakout_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int BW      = 60,
  parameter int BH      = 16,
  parameter int GAP     = 4,
  parameter int ORG_X   = 64,
  parameter int ORG_Y   = 48,
  parameter int SCORE_W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_restart,
  input  logic [9:0]         i_x,
  input  logic [8:0]         i_y,
  input  logic [11:0]        i_bx1,
  input  logic [11:0]        i_bx2,
  input  logic [11:0]        i_by1,
  input  logic [11:0]        i_by2,
  output logic               o_pix,
  output logic               o_hit,
  output logic               o_side,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_clear,
  output logic               o_busy
);

  localparam int N   = ROWS * COLS;
  localparam int KW  = idx_bits(N);
  localparam int RW  = idx_bits(ROWS);
  localparam int CW  = idx_bits(COLS);
  localparam int SW1 = SCORE_W + 1;

  state_e             state_q, state_d;
  logic [N-1:0]       alive_q;
  logic [KW-1:0]      k_q;
  logic [RW-1:0]      r_q;
  logic [CW-1:0]      c_q;
  logic [11:0]        bx1_q, bx2_q, by1_q, by2_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               hit_q, side_q, pix_q;
  logic [11:0]        sx1, sx2, sy1, sy2, px, py;
  logic               hit_w, side_w, last_w;
  logic [SCORE_W:0]   pts, sum;
  logic [N-1:0]       in_brick;

  // Box of the brick under test, from the row/column counters that track k_q.
  always_comb begin
    sx1 = 12'(ORG_X) + 12'(c_q) * 12'(BW + GAP);
    sx2 = sx1 + 12'(BW);
    sy1 = 12'(ORG_Y) + 12'(r_q) * 12'(BH + GAP);
    sy2 = sy1 + 12'(BH);
  end

  brick_hit_test u_hit (
    .alive_i (alive_q[k_q]),
    .x1_i    (sx1),
    .x2_i    (sx2),
    .y1_i    (sy1),
    .y2_i    (sy2),
    .bx1_i   (bx1_q),
    .bx2_i   (bx2_q),
    .by1_i   (by1_q),
    .by2_i   (by2_q),
    .hit_o   (hit_w),
    .side_o  (side_w)
  );

  always_comb begin
`ifdef ROW_POINTS_EN
    pts = SW1'(ROWS) - SW1'(r_q);
`else
    pts = SW1'(1);
`endif
    sum     = {1'b0, score_q} + pts;
    score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    last_w  = (k_q == KW'(N - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_animate) state_d = SCAN;
      SCAN:    if (hit_w || last_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_restart) state_d = IDLE;
  end

  always_comb begin
    o_busy = (state_q != IDLE);
  end

  // Hit side effects are registered on the SCAN->DONE edge so that o_hit,
  // o_score, o_side and o_clear all change together in the DONE cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      alive_q <= '1;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      bx1_q   <= '0;
      bx2_q   <= '0;
      by1_q   <= '0;
      by2_q   <= '0;
      score_q <= '0;
      hit_q   <= 1'b0;
      side_q  <= SIDE_Y;
    end else if (i_restart) begin
      alive_q <= '1;
      score_q <= '0;
      hit_q   <= 1'b0;
      k_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        IDLE: if (i_animate) begin
          bx1_q <= i_bx1;
          bx2_q <= i_bx2;
          by1_q <= i_by1;
          by2_q <= i_by2;
          k_q   <= '0;
          r_q   <= '0;
          c_q   <= '0;
        end
        SCAN: if (hit_w) begin
          alive_q[k_q] <= 1'b0;
          hit_q        <= 1'b1;
          side_q       <= side_w;
          score_q      <= score_d;
        end else if (!last_w) begin
          k_q <= k_q + 1'b1;
          if (c_q == CW'(COLS - 1)) begin
            c_q <= '0;
            r_q <= r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign px = {2'b00, i_x};
  assign py = {3'b000, i_y};

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      localparam logic [11:0] X1 = 12'(ORG_X + gc * (BW + GAP));
      localparam logic [11:0] X2 = 12'(ORG_X + gc * (BW + GAP) + BW);
      localparam logic [11:0] Y1 = 12'(ORG_Y + gr * (BH + GAP));
      localparam logic [11:0] Y2 = 12'(ORG_Y + gr * (BH + GAP) + BH);
      assign in_brick[gr*COLS+gc] = alive_q[gr*COLS+gc] &&
                                    (px > X1) && (px < X2) && (py > Y1) && (py < Y2);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          pix_q <= 1'b0;
    else if (i_pix_stb) pix_q <= |in_brick;
  end

  assign o_pix   = pix_q;
  assign o_hit   = hit_q;
  assign o_side  = side_q;
  assign o_score = score_q;
  assign o_clear = ~|alive_q;

endmodule

// File: doc/brick_field.md
# brick_field

Parametrised ROWS×COLS brick wall for the breakout game, replacing the single fixed block instance. It keeps a per-brick alive bitmap, draws live bricks as a registered pixel flag, and, once per animation frame, scans all bricks against the ball box. It removes at most one struck brick per frame, reports the bounce axis, and keeps the score and level-clear state. It sits beside the paddle and ball instances under the game top; its pixel flag is ORed into the white VGA channels.

## Interface
- ROWS, 4, brick rows
- COLS, 8, brick columns
- BW, 60, brick width (px)
- BH, 16, brick height (px)
- GAP, 4, spacing between bricks (px)
- ORG_X, 64, x of brick (0,0) left edge
- ORG_Y, 48, y of brick (0,0) top edge
- SCORE_W, 9, score width
- i_clk  in  1  100 MHz system clock
- i_rst  in  1  asynchronous, active-high reset
- i_pix_stb  in  1  pixel strobe (i_clk enable)
- i_animate  in  1  end-of-frame pulse, one i_clk cycle
- i_restart  in  1  synchronous re-arm of the wall
- i_x  in  10  current pixel x
- i_y  in  9  current pixel y
- i_bx1, i_bx2, i_by1, i_by2  in  12 each  ball box
- o_pix  out  1  brick pixel flag
- o_hit  out  1  one-cycle brick-hit pulse
- o_side  out  1  bounce axis: 0 = invert dy, 1 = invert dx (valid with o_hit)
- o_score  out  SCORE_W  accumulated points
- o_clear  out  1  all bricks destroyed
- o_busy  out  1  scan in progress

## Operation
- Brick index k = r*COLS + c. Brick box: x1 = ORG_X + c*(BW+GAP), x2 = x1+BW, y1 = ORG_Y + r*(BH+GAP), y2 = y1+BH.
- Draw: pixel is inside brick k when alive[k] and x1<x<x2 and y1<y<y2 (strict). o_pix is the OR over all bricks, registered on i_pix_stb.
- Overlap: ball hits brick k when alive[k] and bx1<x2 and bx2>x1 and by1<y2 and by2>y1.
- FSM states:
  - IDLE: on i_animate, latch the ball box, set k=0, go to SCAN.
  - SCAN: test one brick per i_clk. On the first overlap, record k and side, then go to DONE. If k=N-1 is reached with no overlap, go to DONE with no hit.
  - DONE: if a hit was recorded, clear alive[k], pulse o_hit, add points to the score, and drive o_side. Then return to IDLE.
- Side rule: ox = min(bx2,x2) − max(bx1,x1) and oy = min(by2,y2) − max(by1,y1). If ox ≥ oy then side = 0, else side = 1.
- Multiple overlapping bricks: the lowest index wins. Only one brick is removed per frame.
- Score saturates at 2^SCORE_W − 1.
- o_clear = (alive == 0). While o_clear is set, scans still run but never hit.
- i_animate is ignored while o_busy is set.
- i_restart (any state): sets alive to all-ones, clears score, o_hit and o_clear, aborts any scan, and returns to IDLE on the next cycle.

## Timing
- Reset values: alive all-ones, state IDLE, o_pix 0, o_hit 0, o_side 0, o_score 0, o_clear 0, o_busy 0.
- o_busy rises the cycle after i_animate and stays high through DONE.
- Hit at index k: o_hit is asserted k+2 cycles after the i_animate cycle.
- No hit: scan takes ROWS*COLS cycles, then one DONE cycle.
- o_score, o_side and o_clear update in the same cycle as o_hit.
- o_pix latency: one i_pix_stb after the pixel coordinates are presented.
- i_rst asserted mid-scan: immediate return to reset values. No partial brick removal.

## Configuration
- ROW_POINTS_EN defined: a hit on row r scores ROWS − r points (top row is worth the most).
- ROW_POINTS_EN undefined: every brick scores 1 point.

## Structure
- Shared package breakout_pkg holds:
  - brick index width $clog2(ROWS*COLS)
  - side constants SIDE_Y=0 and SIDE_X=1
  - the FSM state enum (IDLE, SCAN, DONE)
- One sub-module, brick_hit_test: combinational overlap test plus side computation for one brick box against the ball box. It is instantiated once and driven by the scan index. The draw path uses a separate inline comparator array.

## Test plan
- Reset, then pixel (90,56) with i_pix_stb → o_pix = 1. Pixel (126,56) (gap) → o_pix = 0.
- Ball box 90..100 × 60..70, pulse i_animate → o_hit after 2 cycles, o_side = 0, alive[0] cleared. Score becomes 4 with ROW_POINTS_EN, 1 without.
- Ball box 120..130 × 50..60, which overlaps bricks 0 and 1 → only brick 0 is removed, o_side = 1. Repeat the frame → brick 1 is removed at k=1 (o_hit 3 cycles after i_animate).
- Ball box 0..10 × 300..310 → no o_hit. o_busy is high for 33 cycles.
- Remove all 32 bricks over successive frames → o_clear = 1 and score = 80 (with ROW_POINTS_EN). Then i_restart → o_clear = 0, score = 0, o_pix returns for brick (0,0).
- Assert i_rst 5 cycles into a scan, then release → state IDLE, o_busy = 0, all bricks alive.
